// File: rtl/display_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_sequencer_pkg
//  Description : Shared FSM state encoding, display constants and a helper
//                for sizing the result-hold counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_sequencer_pkg;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Digit code shown on every position when the value does not fit
    localparam logic [3:0]  DIG_ERR = 4'hE;

    // Largest value representable on four decimal digits
    localparam int unsigned BCD_MAX = 9999;

    // Width of a down-counter that must hold CYCLES-1; never narrower than 1
    function automatic int hold_w(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage : display_sequencer_pkg
`default_nettype wire

// File: rtl/display_sequencer_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential shift-add-3 binary to BCD converter. start_i
//                latches the operand and clears the accumulator; BIN_W shift
//                steps follow. done_o is high during the final step, so bcd_o
//                and ovf_o hold the finished result from the next cycle on.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import display_sequencer_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             done_o,
    output logic [15:0]      bcd_o,
    output logic             ovf_o
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    logic [BIN_W-1:0] shift_q;
    logic [15:0]      bcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             ovf_q;
    logic [15:0]      w_adj;

    // Add-3 correction on every nibble that would reach 10 or more after shifting
    for (genvar g = 0; g < 4; g++) begin : g_nib
        assign w_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? (bcd_q[4*g +: 4] + 4'd3)
                                                           :  bcd_q[4*g +: 4];
    end

    // Load on start, then shift one operand bit into the corrected accumulator per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (start_i) begin
            shift_q <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            ovf_q   <= (32'(bin_i) > BCD_MAX);
        end else if (busy_q) begin
            bcd_q   <= {w_adj[14:0], shift_q[BIN_W-1]};
            shift_q <= {shift_q[BIN_W-2:0], 1'b0};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o = busy_q && (cnt_q == LAST_STEP);
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/display_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : display_sequencer
//  Description : Shares the 4-digit display between the live operand and the
//                sqrt result. A result owns the display for a hold window; the
//                selected value is converted to BCD and presented atomically
//                with a leading-zero blank mask and an overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_sequencer
    import display_sequencer_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int HOLD_MS  = 2000,
    parameter int BIN_W    = 14
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [BIN_W-1:0] op_val,
    input  logic [BIN_W-1:0] res_val,
    input  logic             res_valid,
    output logic [3:0]       dig1,
    output logic [3:0]       dig2,
    output logic [3:0]       dig3,
    output logic [3:0]       dig4,
    output logic [3:0]       blank,
    output logic             src,
    output logic             ovf
);

    localparam int HOLD_CYC = HOLD_MS * (CLK_FREQ / 1000);
    localparam int HOLD_W   = hold_w(HOLD_CYC);
    // A zero-length hold still grants the result one cycle of ownership
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

    state_e           state_q, state_d;
    logic             src_q;
    logic [HOLD_W-1:0] hold_q;
    logic [BIN_W-1:0] res_q;
    logic             pend_q;
    logic [BIN_W-1:0] last_q;
    logic             last_src_q;
    logic [BIN_W-1:0] cval_q;
    logic             csrc_q;
    logic [15:0]      dig_q;
    logic [3:0]       blank_q;
    logic             ovf_q;

    logic [BIN_W-1:0] w_sel;
    logic             w_trig;
    logic             w_pend_set;
    logic             w_start;
    logic             w_conv_done;
    logic [15:0]      w_bcd;
    logic             w_bcd_ovf;
    logic [3:0]       w_blank;

    assign w_sel  = src_q ? res_q : op_val;
    assign w_trig = (w_sel != last_q) || (src_q != last_src_q) || pend_q;

    // Any disturbance while a conversion is in flight forces one more pass afterwards
    assign w_pend_set = ((state_q == ST_LOAD) && res_valid) ||
                        ((state_q == ST_CONV) && (res_valid || (w_sel != cval_q) || (src_q != csrc_q)));

    // Leading zeros are blanked from the left; the rightmost digit is always lit
    assign w_blank[3] = (w_bcd[15:12] == 4'd0);
    assign w_blank[2] = w_blank[3] && (w_bcd[11:8] == 4'd0);
    assign w_blank[1] = w_blank[2] && (w_bcd[7:4] == 4'd0);
    assign w_blank[0] = 1'b0;

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (clr),
        .start_i (w_start),
        .bin_i   (w_sel),
        .done_o  (w_conv_done),
        .bcd_o   (w_bcd),
        .ovf_o   (w_bcd_ovf)
    );

    // Result ownership: newest result wins and restarts the hold window
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            src_q  <= 1'b0;
            hold_q <= '0;
            res_q  <= '0;
        end else if (res_valid) begin
            src_q  <= 1'b1;
            hold_q <= HOLD_LOAD;
            res_q  <= res_val;
        end else if (src_q) begin
            if (hold_q == '0) begin
                src_q <= 1'b0;
            end else begin
                hold_q <= hold_q - 1'b1;
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state and converter start strobe
    always_comb begin
        state_d = state_q;
        w_start = 1'b0;
        case (state_q)
            ST_IDLE: if (w_trig) state_d = ST_LOAD;
            ST_LOAD: begin
                w_start = 1'b1;
                state_d = ST_CONV;
            end
            ST_CONV: if (w_conv_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Remember what is being converted and whether it was disturbed meanwhile
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cval_q     <= '0;
            csrc_q     <= 1'b0;
            pend_q     <= 1'b0;
            last_q     <= '0;
            last_src_q <= 1'b0;
        end else begin
            if (state_q == ST_LOAD) begin
                cval_q <= w_sel;
                csrc_q <= src_q;
            end
            if (state_q == ST_DONE) begin
                pend_q     <= 1'b0;
                last_q     <= cval_q;
                last_src_q <= csrc_q;
            end else if (w_pend_set) begin
                pend_q <= 1'b1;
            end
        end
    end

    // Publish a finished conversion to the display in one step
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dig_q   <= '0;
            blank_q <= 4'b1110;
            ovf_q   <= 1'b0;
        end else if (state_q == ST_DONE) begin
            if (w_bcd_ovf) begin
                dig_q   <= {4{DIG_ERR}};
                blank_q <= 4'b0000;
                ovf_q   <= 1'b1;
            end else begin
                dig_q   <= w_bcd;
                blank_q <= w_blank;
                ovf_q   <= 1'b0;
            end
        end
    end

    assign dig1  = dig_q[15:12];
    assign dig2  = dig_q[11:8];
    assign dig3  = dig_q[7:4];
    assign dig4  = dig_q[3:0];
    assign blank = blank_q;
    assign ovf   = ovf_q;
    assign src   = src_q;

endmodule : display_sequencer
`default_nettype wire

// File: tb/tb_display_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_sequencer
//  Description : Self-checking bench for display_sequencer with a behavioural
//                reference model and directed plus randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_sequencer;

    localparam int CLK_FREQ = 1000;
    localparam int HOLD_MS  = 5;
    localparam int BIN_W    = 14;
    localparam int HOLD     = HOLD_MS * (CLK_FREQ / 1000);
    localparam int CONV_LAT = BIN_W + 2;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic [BIN_W-1:0] op_val = '0;
    logic [BIN_W-1:0] res_val = '0;
    logic             res_valid = 1'b0;
    logic [3:0]       dig1, dig2, dig3, dig4, blank;
    logic             src, ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    display_sequencer #(
        .CLK_FREQ (CLK_FREQ),
        .HOLD_MS  (HOLD_MS),
        .BIN_W    (BIN_W)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .op_val    (op_val),
        .res_val   (res_val),
        .res_valid (res_valid),
        .dig1      (dig1),
        .dig2      (dig2),
        .dig3      (dig3),
        .dig4      (dig4),
        .blank     (blank),
        .src       (src),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // What the display must show for a value: {ovf, blank, dig1..dig4}
    function automatic logic [20:0] exp_word(input int v);
        int d1, d2, d3, d4;
        logic [3:0] b;
        if (v > 9999) return {1'b1, 4'b0000, 16'hEEEE};
        d1 = v / 1000;
        d2 = (v / 100) % 10;
        d3 = (v / 10) % 10;
        d4 = v % 10;
        b[3] = (d1 == 0);
        b[2] = b[3] && (d2 == 0);
        b[1] = b[2] && (d3 == 0);
        b[0] = 1'b0;
        return {1'b0, b, 4'(d1), 4'(d2), 4'(d3), 4'(d4)};
    endfunction

    // Reference model: ownership timer plus a conversion that samples the
    // selected value one cycle after it starts and publishes CONV_LAT cycles
    // after it starts. Reset shows value 0.
    int m_src, m_res, m_hold;
    int m_busy_age;   // 0 = no conversion running, else cycles since start
    int m_val, m_vsrc, m_last, m_lsrc, m_pend;
    int m_shown;

    initial begin
        forever begin
            @(posedge clk or negedge clr);
            if (!clr) begin
                m_src = 0; m_res = 0; m_hold = 0;
                m_busy_age = 0; m_val = 0; m_vsrc = 0;
                m_last = 0; m_lsrc = 0; m_pend = 0; m_shown = 0;
            end else begin
                int sel;
                sel = (m_src != 0) ? m_res : int'(op_val);
                if (m_busy_age == 0) begin
                    if (sel != m_last || m_src != m_lsrc || m_pend != 0) m_busy_age = 1;
                end else if (m_busy_age == 1) begin
                    m_val  = sel;
                    m_vsrc = m_src;
                    if (res_valid) m_pend = 1;
                    m_busy_age = 2;
                end else if (m_busy_age < CONV_LAT) begin
                    if (res_valid || sel != m_val || m_src != m_vsrc) m_pend = 1;
                    m_busy_age = m_busy_age + 1;
                end else begin
                    m_shown = m_val;
                    m_last  = m_val;
                    m_lsrc  = m_vsrc;
                    m_pend  = 0;
                    m_busy_age = 0;
                end
                if (res_valid) begin
                    m_src  = 1;
                    m_res  = int'(res_val);
                    m_hold = (HOLD == 0) ? 0 : HOLD - 1;
                end else if (m_src != 0) begin
                    if (m_hold == 0) m_src = 0;
                    else m_hold = m_hold - 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            n_cmp++;
            if ({ovf, blank, dig1, dig2, dig3, dig4} !== exp_word(m_shown) || src !== m_src[0]) begin
                n_fail++;
                $display("FAIL model t=%0t: got ovf=%b blank=%b dig=%h%h%h%h src=%b, want word=%h src=%0d",
                         $time, ovf, blank, dig1, dig2, dig3, dig4, src, exp_word(m_shown), m_src);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string name, input logic [20:0] want, input logic want_src);
        n_cmp++;
        if ({ovf, blank, dig1, dig2, dig3, dig4} !== want || src !== want_src) begin
            n_fail++;
            $display("FAIL %s: got ovf=%b blank=%b dig=%h%h%h%h src=%b, want ovf=%b blank=%b dig=%h src=%b",
                     name, ovf, blank, dig1, dig2, dig3, dig4, src,
                     want[20], want[19:16], want[15:0], want_src);
        end
    endtask

    task automatic chk_src(input string name, input logic want_src);
        n_cmp++;
        if (src !== want_src) begin
            n_fail++;
            $display("FAIL %s: got src=%b, want src=%b", name, src, want_src);
        end
    endtask

    task automatic wait_for(input string name, input logic [20:0] want, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if ({ovf, blank, dig1, dig2, dig3, dig4} === want) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: got ovf=%b blank=%b dig=%h%h%h%h, want ovf=%b blank=%b dig=%h within %0d cycles",
                     name, ovf, blank, dig1, dig2, dig3, dig4, want[20], want[19:16], want[15:0], budget);
        end
    endtask

    initial begin
        #1 clr = 1'b0;
        op_val = 14'd1234;
        tick(3);
        chk("reset_state", {1'b0, 4'b1110, 16'h0000}, 1'b0);

        // Release: conversion starts immediately, result 16 cycles after leaving idle
        clr = 1'b1;
        tick(16);
        @(negedge clk);
        chk("latency_before", {1'b0, 4'b1110, 16'h0000}, 1'b0);
        tick(1);
        @(negedge clk);
        chk("latency_at", {1'b0, 4'b0000, 16'h1234}, 1'b0);

        tick(1); op_val = 14'd7;
        wait_for("op_7", {1'b0, 4'b1110, 16'h0007}, 30);
        tick(1); op_val = 14'd0;
        wait_for("op_0", {1'b0, 4'b1110, 16'h0000}, 30);
        tick(1); op_val = 14'd1234;
        wait_for("op_1234", {1'b0, 4'b0000, 16'h1234}, 30);

        // Result takes the display, then hands it back after the hold window
        tick(1); res_val = 14'd99; res_valid = 1'b1;
        tick(1); res_valid = 1'b0;
        @(negedge clk);
        chk("res_src_next", {1'b0, 4'b0000, 16'h1234}, 1'b1);
        wait_for("res_99", {1'b0, 4'b1100, 16'h0099}, 30);
        chk_src("res_hold_over", 1'b0);
        wait_for("back_to_op", {1'b0, 4'b0000, 16'h1234}, 40);

        tick(1); op_val = 14'd12000;
        wait_for("overflow", {1'b1, 4'b0000, 16'hEEEE}, 30);
        tick(1); op_val = 14'd9999;
        wait_for("max_9999", {1'b0, 4'b0000, 16'h9999}, 30);

        // Two results during a conversion; hold restarts on the second
        tick(1); op_val = 14'd555;
        tick(5); res_val = 14'd10; res_valid = 1'b1;
        tick(1); res_valid = 1'b0;
        tick(4); res_val = 14'd321; res_valid = 1'b1;
        tick(1); res_valid = 1'b0;
        tick(4);
        @(negedge clk);
        chk_src("hold_last_cycle", 1'b1);
        tick(1);
        @(negedge clk);
        chk_src("hold_expired", 1'b0);
        wait_for("settle_555", {1'b0, 4'b1000, 16'h0555}, 60);

        // Asynchronous clear in the middle of a conversion
        tick(1); op_val = 14'd5678;
        tick(6); clr = 1'b0;
        #1;
        chk("clr_async", {1'b0, 4'b1110, 16'h0000}, 1'b0);
        op_val = 14'd42;
        tick(1); clr = 1'b1;
        wait_for("after_clr_42", {1'b0, 4'b1100, 16'h0042}, 30);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0) op_val = 14'($urandom_range(10000, 16383));
                else                           op_val = 14'($urandom_range(0, 9999));
            end
            res_val   = ($urandom_range(0, 4) == 0) ? 14'($urandom_range(10000, 16383))
                                                    : 14'($urandom_range(0, 9999));
            res_valid = ($urandom_range(0, 59) == 0);
            clr       = ($urandom_range(0, 799) != 0);
            tick(1);
        end
        res_valid = 1'b0;
        clr = 1'b1;
        tick(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_display_sequencer
`default_nettype wire
